// File: rtl/branch_predictor_pkg.sv
// Shared types for the dynamic branch predictor: BTB entry layout and
// the 2-bit saturating counter with its update rule.
package bp_pkg;

  localparam int unsigned BP_PC_WIDTH  = 32;
  // Tags are stored at the widest possible size and zero-extended on compare.
  localparam int unsigned BP_TAG_WIDTH = BP_PC_WIDTH - 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_WIDTH-1:0] tag;
    logic [BP_PC_WIDTH-1:0]  target;
    ctr_t                    ctr;
  } btb_entry_t;

  function automatic ctr_t sat_update(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    case (c)
      STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  n = taken ? STRONG_T : WEAK_T;
      default:   n = WEAK_NT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/Decode-side signal bundle between the pipeline (master) and the
// branch predictor (slave).
interface branch_predictor_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] pc_f;
  logic                stall_d;
  logic                pred_taken_f;
  logic [PC_WIDTH-1:0] pred_pc_f;
  logic                branch_d;
  logic                taken_d;
  logic [PC_WIDTH-1:0] target_d;
  logic [PC_WIDTH-1:0] pc_plus4_d;
  logic                restart;
  logic [PC_WIDTH-1:0] restart_pc;
  logic [31:0]         branch_cnt;
  logic [31:0]         mispred_cnt;

  modport master (
    output pc_f, stall_d, branch_d, taken_d, target_d, pc_plus4_d,
    input  pred_taken_f, pred_pc_f, restart, restart_pc, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pc_f, stall_d, branch_d, taken_d, target_d, pc_plus4_d,
    output pred_taken_f, pred_pc_f, restart, restart_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB storage: async-reset valid/counter bits, unreset tag/target
// payload, two combinational read ports (fetch lookup, decode training) and one write port.
module btb_table
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output btb_entry_t            rd_entry,
  input  logic [INDEX_BITS-1:0] train_idx,
  output btb_entry_t            train_entry,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  btb_entry_t            wr_entry
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic                    valid_q  [ENTRIES];
  ctr_t                    ctr_q    [ENTRIES];
  logic [BP_TAG_WIDTH-1:0] tag_q    [ENTRIES];
  logic [BP_PC_WIDTH-1:0]  target_q [ENTRIES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WEAK_NT;
      end
    end else if (we) begin
      valid_q[wr_idx] <= wr_entry.valid;
      ctr_q[wr_idx]   <= wr_entry.ctr;
    end
  end

  // Payload is only meaningful behind valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  always_comb begin
    rd_entry.valid     = valid_q[rd_idx];
    rd_entry.tag       = tag_q[rd_idx];
    rd_entry.target    = target_q[rd_idx];
    rd_entry.ctr       = ctr_q[rd_idx];
    train_entry.valid  = valid_q[train_idx];
    train_entry.tag    = tag_q[train_idx];
    train_entry.target = target_q[train_idx];
    train_entry.ctr    = ctr_q[train_idx];
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB lookup in Fetch, prediction carried through
// an F/D register, mispredict detection and table training in Decode.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);

  logic [INDEX_BITS-1:0]   idx_f;
  logic [INDEX_BITS-1:0]   idx_d;
  logic [BP_TAG_WIDTH-1:0] tag_f;
  logic [BP_TAG_WIDTH-1:0] tag_d;
  logic [PC_WIDTH-1:0]     pc_d;
  btb_entry_t              rd_f;
  btb_entry_t              rd_d;
  btb_entry_t              wr_entry;
  logic                    we;
  logic                    hit_f;
  logic                    train_hit;
  logic                    pred_taken_f;
  logic                    pred_taken_d;
  logic [PC_WIDTH-1:0]     pred_target_d;
  logic                    resolve;
  logic                    restart;
  logic [31:0]             branch_cnt;
  logic [31:0]             mispred_cnt;

  assign pc_d  = bp.pc_plus4_d - PC_WIDTH'(4);
  assign idx_f = bp.pc_f[INDEX_BITS+1:2];
  assign idx_d = pc_d[INDEX_BITS+1:2];
  assign tag_f = BP_TAG_WIDTH'(bp.pc_f >> (INDEX_BITS + 2));
  assign tag_d = BP_TAG_WIDTH'(pc_d >> (INDEX_BITS + 2));

  btb_table #(.INDEX_BITS(INDEX_BITS)) u_btb (
    .clk         (clk),
    .reset       (reset),
    .rd_idx      (idx_f),
    .rd_entry    (rd_f),
    .train_idx   (idx_d),
    .train_entry (rd_d),
    .we          (we),
    .wr_idx      (idx_d),
    .wr_entry    (wr_entry)
  );

  assign hit_f        = rd_f.valid && (rd_f.tag == tag_f);
  assign pred_taken_f = hit_f && rd_f.ctr[1];

  assign bp.pred_taken_f = pred_taken_f;
  assign bp.pred_pc_f    = pred_taken_f ? PC_WIDTH'(rd_f.target) : bp.pc_f + PC_WIDTH'(4);

  assign resolve = (bp.branch_d || pred_taken_d) && !bp.stall_d;

  always_comb begin
    restart = 1'b0;
    if (resolve) begin
      if (bp.branch_d) begin
        restart = (bp.taken_d != pred_taken_d) ||
                  (bp.taken_d && pred_taken_d && (pred_target_d != bp.target_d));
      end else begin
        restart = pred_taken_d;
      end
    end
  end

  assign bp.restart    = restart;
  assign bp.restart_pc = (bp.branch_d && bp.taken_d) ? bp.target_d : bp.pc_plus4_d;

  // Training reads the entry as it stands now, so back-to-back resolutions
  // of the same branch build on each other rather than on a stale fetch copy.
  always_comb begin
    we        = 1'b0;
    wr_entry  = rd_d;
    train_hit = rd_d.valid && (rd_d.tag == tag_d);
    if (resolve) begin
      if (bp.branch_d) begin
        if (train_hit) begin
          we           = 1'b1;
          wr_entry.ctr = sat_update(rd_d.ctr, bp.taken_d);
          if (bp.taken_d) wr_entry.target = BP_PC_WIDTH'(bp.target_d);
        end else if (bp.taken_d) begin
          we              = 1'b1;
          wr_entry.valid  = 1'b1;
          wr_entry.tag    = tag_d;
          wr_entry.target = BP_PC_WIDTH'(bp.target_d);
          wr_entry.ctr    = WEAK_T;
        end
      end else if (pred_taken_d) begin
        we             = 1'b1;
        wr_entry.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
    end else if (restart) begin
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
    end else if (!bp.stall_d) begin
      pred_taken_d  <= pred_taken_f;
      pred_target_d <= PC_WIDTH'(rd_f.target);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && bp.branch_d) branch_cnt <= branch_cnt + 32'd1;
      if (restart) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign bp.branch_cnt  = branch_cnt;
  assign bp.mispred_cnt = mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: cold allocation, counter
// training, stall handling, index aliasing and reset during a mispredict.
module tb_branch_predictor;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  branch_predictor_if #(.PC_WIDTH(32)) bp_bus ();

  branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] pc, input logic br, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] pc4, input logic stall);
    bp_bus.pc_f       = pc;
    bp_bus.branch_d   = br;
    bp_bus.taken_d    = tk;
    bp_bus.target_d   = tgt;
    bp_bus.pc_plus4_d = pc4;
    bp_bus.stall_d    = stall;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(32'h0040_0010, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got=%b exp=0", bp_bus.pred_taken_f); end
    checks++;
    if (bp_bus.pred_pc_f !== 32'h0040_0014) begin errors++; $display("FAIL reset_pred_pc got=%h exp=00400014", bp_bus.pred_pc_f); end
    checks++;
    if (bp_bus.branch_cnt !== 32'd0) begin errors++; $display("FAIL reset_branch_cnt got=%0d exp=0", bp_bus.branch_cnt); end
    checks++;
    if (bp_bus.mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_mispred_cnt got=%0d exp=0", bp_bus.mispred_cnt); end
    checks++;
    if (bp_bus.restart !== 1'b0) begin errors++; $display("FAIL reset_restart got=%b exp=0", bp_bus.restart); end
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_cold_taken();
    drive(32'h0040_0020, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.pred_taken_f !== 1'b0) begin errors++; $display("FAIL cold_lookup_miss got=%b exp=0", bp_bus.pred_taken_f); end
    next_cycle();
    drive(32'h0040_0024, 1'b1, 1'b1, 32'h0040_0040, 32'h0040_0024, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.restart !== 1'b1) begin errors++; $display("FAIL cold_restart got=%b exp=1", bp_bus.restart); end
    checks++;
    if (bp_bus.restart_pc !== 32'h0040_0040) begin errors++; $display("FAIL cold_restart_pc got=%h exp=00400040", bp_bus.restart_pc); end
    next_cycle();
    drive(32'h0040_0020, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.pred_taken_f !== 1'b1) begin errors++; $display("FAIL cold_alloc_pred got=%b exp=1", bp_bus.pred_taken_f); end
    checks++;
    if (bp_bus.pred_pc_f !== 32'h0040_0040) begin errors++; $display("FAIL cold_alloc_pred_pc got=%h exp=00400040", bp_bus.pred_pc_f); end
    checks++;
    if (bp_bus.branch_cnt !== 32'd1 || bp_bus.mispred_cnt !== 32'd1) begin
      errors++; $display("FAIL cold_counts got=%0d/%0d exp=1/1", bp_bus.branch_cnt, bp_bus.mispred_cnt);
    end
    next_cycle();
  endtask

  task automatic test_counter_training();
    // Two more taken resolutions (10->11->11), each correctly predicted
    for (int i = 0; i < 2; i++) begin
      drive(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0040, 32'h0040_0024, 1'b0);
      @(negedge clk);
      checks++;
      if (bp_bus.restart !== 1'b0) begin errors++; $display("FAIL train_taken_restart[%0d] got=%b exp=0", i, bp_bus.restart); end
      next_cycle();
    end
    drive(32'h0040_0020, 1'b1, 1'b0, 32'h0040_0040, 32'h0040_0024, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.restart !== 1'b1) begin errors++; $display("FAIL train_nt_restart got=%b exp=1", bp_bus.restart); end
    checks++;
    if (bp_bus.restart_pc !== 32'h0040_0024) begin errors++; $display("FAIL train_nt_restart_pc got=%h exp=00400024", bp_bus.restart_pc); end
    next_cycle();
    drive(32'h0040_0020, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.pred_taken_f !== 1'b1) begin errors++; $display("FAIL train_still_taken got=%b exp=1", bp_bus.pred_taken_f); end
    checks++;
    if (bp_bus.pred_pc_f !== 32'h0040_0040) begin errors++; $display("FAIL train_pred_pc got=%h exp=00400040", bp_bus.pred_pc_f); end
    checks++;
    if (bp_bus.branch_cnt !== 32'd4 || bp_bus.mispred_cnt !== 32'd2) begin
      errors++; $display("FAIL train_counts got=%0d/%0d exp=4/2", bp_bus.branch_cnt, bp_bus.mispred_cnt);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive(32'h0040_0024, 1'b1, 1'b1, 32'h0040_0040, 32'h0040_0024, 1'b1);
      @(negedge clk);
      checks++;
      if (bp_bus.restart !== 1'b0) begin errors++; $display("FAIL stall_restart[%0d] got=%b exp=0", i, bp_bus.restart); end
      next_cycle();
    end
    checks++;
    if (bp_bus.branch_cnt !== 32'd4) begin errors++; $display("FAIL stall_no_count got=%0d exp=4", bp_bus.branch_cnt); end
    drive(32'h0040_0100, 1'b1, 1'b1, 32'h0040_0040, 32'h0040_0024, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.restart !== 1'b0) begin errors++; $display("FAIL stall_release_restart got=%b exp=0", bp_bus.restart); end
    next_cycle();
    drive(32'h0040_0120, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.branch_cnt !== 32'd5 || bp_bus.mispred_cnt !== 32'd2) begin
      errors++; $display("FAIL stall_counts got=%0d/%0d exp=5/2", bp_bus.branch_cnt, bp_bus.mispred_cnt);
    end
  endtask

  task automatic test_alias();
    // Continues the cycle left open by test_stall: pc_f = 0x00400120 in Fetch
    checks++;
    if (bp_bus.pred_taken_f !== 1'b0) begin errors++; $display("FAIL alias_pre_miss got=%b exp=0", bp_bus.pred_taken_f); end
    next_cycle();
    drive(32'h0040_0200, 1'b1, 1'b1, 32'h0040_0200, 32'h0040_0124, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.restart !== 1'b1 || bp_bus.restart_pc !== 32'h0040_0200) begin
      errors++; $display("FAIL alias_restart got=%b/%h exp=1/00400200", bp_bus.restart, bp_bus.restart_pc);
    end
    next_cycle();
    drive(32'h0040_0020, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.pred_taken_f !== 1'b0 || bp_bus.pred_pc_f !== 32'h0040_0024) begin
      errors++; $display("FAIL alias_evicted got=%b/%h exp=0/00400024", bp_bus.pred_taken_f, bp_bus.pred_pc_f);
    end
    checks++;
    if (bp_bus.branch_cnt !== 32'd6 || bp_bus.mispred_cnt !== 32'd3) begin
      errors++; $display("FAIL alias_counts got=%0d/%0d exp=6/3", bp_bus.branch_cnt, bp_bus.mispred_cnt);
    end
    next_cycle();
    drive(32'h0040_0120, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.pred_taken_f !== 1'b1 || bp_bus.pred_pc_f !== 32'h0040_0200) begin
      errors++; $display("FAIL alias_new_hit got=%b/%h exp=1/00400200", bp_bus.pred_taken_f, bp_bus.pred_pc_f);
    end
    next_cycle();
  endtask

  task automatic test_reset_mispredict();
    // F/D holds a taken prediction for 0x00400120; resolve it not-taken
    drive(32'h0040_0120, 1'b1, 1'b0, 32'h0040_0200, 32'h0040_0124, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.restart !== 1'b1 || bp_bus.restart_pc !== 32'h0040_0124) begin
      errors++; $display("FAIL rst_mp_restart got=%b/%h exp=1/00400124", bp_bus.restart, bp_bus.restart_pc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bp_bus.restart !== 1'b0) begin errors++; $display("FAIL rst_mp_restart_cleared got=%b exp=0", bp_bus.restart); end
    checks++;
    if (bp_bus.pred_taken_f !== 1'b0 || bp_bus.pred_pc_f !== 32'h0040_0124) begin
      errors++; $display("FAIL rst_mp_lookup got=%b/%h exp=0/00400124", bp_bus.pred_taken_f, bp_bus.pred_pc_f);
    end
    checks++;
    if (bp_bus.branch_cnt !== 32'd0 || bp_bus.mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_mp_counts got=%0d/%0d exp=0/0", bp_bus.branch_cnt, bp_bus.mispred_cnt);
    end
    next_cycle();
    drive(32'h0040_0120, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bp_bus.pred_taken_f !== 1'b0 || bp_bus.pred_pc_f !== 32'h0040_0124) begin
      errors++; $display("FAIL post_rst_miss_120 got=%b/%h exp=0/00400124", bp_bus.pred_taken_f, bp_bus.pred_pc_f);
    end
    checks++;
    if (bp_bus.restart !== 1'b0 || bp_bus.branch_cnt !== 32'd0 || bp_bus.mispred_cnt !== 32'd0) begin
      errors++; $display("FAIL post_rst_state got=%b/%0d/%0d exp=0/0/0", bp_bus.restart, bp_bus.branch_cnt, bp_bus.mispred_cnt);
    end
    next_cycle();
    drive(32'h0040_0020, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bp_bus.pred_taken_f !== 1'b0 || bp_bus.pred_pc_f !== 32'h0040_0024) begin
      errors++; $display("FAIL post_rst_miss_020 got=%b/%h exp=0/00400024", bp_bus.pred_taken_f, bp_bus.pred_pc_f);
    end
    next_cycle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_cold_taken();
    test_counter_training();
    test_stall();
    test_alias();
    test_reset_mispredict();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
